// File: rtl/ecc24_pkg.sv
// Shared SECDED definitions for the 24-bit ECC FIFO path.
// The encoder and the read-side checker both import this package.
package ecc24_pkg;

   localparam int DATA_WIDTH   = 24;
   localparam int PARITY_WIDTH = 6;
   localparam int CW_WIDTH     = DATA_WIDTH + PARITY_WIDTH;

   typedef enum logic [1:0] {
      INJ_NONE = 2'b00,
      INJ_SBIT = 2'b01,
      INJ_DBIT = 2'b10,
      INJ_PBIT = 2'b11
   } inj_mode_e;

   // Each mask selects the data bits covered by one parity bit.
   localparam logic [DATA_WIDTH-1:0] P0_SET = 24'hAAAD5B;
   localparam logic [DATA_WIDTH-1:0] P1_SET = 24'h33366D;
   localparam logic [DATA_WIDTH-1:0] P2_SET = 24'hC3C78E;
   localparam logic [DATA_WIDTH-1:0] P3_SET = 24'hFC07F0;
   localparam logic [DATA_WIDTH-1:0] P4_SET = 24'hFFF800;
   localparam logic [DATA_WIDTH-1:0] P5_SET = 24'hA65CB7;

   function automatic logic [PARITY_WIDTH-1:0] ecc24_encode(input logic [DATA_WIDTH-1:0] d);
      logic [PARITY_WIDTH-1:0] p;
      p[0] = ^(d & P0_SET);
      p[1] = ^(d & P1_SET);
      p[2] = ^(d & P2_SET);
      p[3] = ^(d & P3_SET);
      p[4] = ^(d & P4_SET);
      p[5] = ^(d & P5_SET);
      return p;
   endfunction

endpackage

// File: rtl/ecc_skid_buf.sv
// Two-entry valid/ready register slice: main output register plus one skid entry.
// in_ready is a flop equal to !skid_valid, so upstream never sees a combinational path from out_ready.
module ecc_skid_buf #(
   parameter int WIDTH = 30
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             skid_valid;
   logic [WIDTH-1:0] skid_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         in_ready   <= 1'b1;
      end else if (skid_valid) begin
         // Skid is only ever occupied behind a valid main entry.
         if (out_ready) begin
            out_data   <= skid_data;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
         end
      end else if (in_valid) begin
         if (!out_valid || out_ready) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
         end else begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
            in_ready   <= 1'b0;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/ecc_24_wr_enc.sv
// Write-side SECDED encoder: encodes accepted words, optionally corrupts them for
// checker testing, and registers the 30-bit codeword through a skid-buffered slice.
module ecc_24_wr_enc
   import ecc24_pkg::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic [PARITY_WIDTH-1:0] out_parity,
   input  logic                    inj_en,
   input  logic [1:0]              inj_mode,
   input  logic [4:0]              inj_pos,
   input  logic                    inj_oneshot,
   output logic                    inj_done,
   output logic [CNT_WIDTH-1:0]    enc_cnt,
   output logic [CNT_WIDTH-1:0]    inj_cnt
);

   logic                    accept;
   logic                    inj_en_q;
   logic                    armed;
   logic                    inj_rise;
   logic                    inj_active;
   logic                    inj_acc;
   logic [4:0]              dpos;
   logic [4:0]              dpos_nxt;
   logic [2:0]              ppos;
   logic [DATA_WIDTH-1:0]   cw_data;
   logic [PARITY_WIDTH-1:0] cw_parity;
   logic [CW_WIDTH-1:0]     slice_out;
   inj_mode_e               mode;

   assign accept   = in_valid & in_ready;
   assign mode     = inj_mode_e'(inj_mode);
   assign inj_rise = inj_en & ~inj_en_q & (mode != INJ_NONE);

   // The rising-edge cycle itself counts as armed so a word presented together
   // with the enable edge is still corrupted in oneshot mode.
   assign inj_active = inj_en & (mode != INJ_NONE) & (~inj_oneshot | armed | inj_rise);
   assign inj_acc    = accept & inj_active;

   assign dpos     = (inj_pos < 5'd24) ? inj_pos : 5'd0;
   assign dpos_nxt = (dpos == 5'd23) ? 5'd0 : dpos + 5'd1;
   assign ppos     = (inj_pos < 5'd6) ? inj_pos[2:0] : 3'd0;

   always_comb begin
      cw_data   = in_data;
      cw_parity = ecc24_encode(in_data);
      if (inj_active) begin
         case (mode)
            INJ_SBIT: cw_data = cw_data ^ (24'd1 << dpos);
            INJ_DBIT: cw_data = cw_data ^ (24'd1 << dpos) ^ (24'd1 << dpos_nxt);
            INJ_PBIT: cw_parity = cw_parity ^ (6'd1 << ppos);
            default:  cw_data = in_data;
         endcase
      end
   end

   ecc_skid_buf #(
      .WIDTH (CW_WIDTH)
   ) u_slice (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({cw_parity, cw_data}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (slice_out)
   );

   assign out_data   = slice_out[DATA_WIDTH-1:0];
   assign out_parity = slice_out[CW_WIDTH-1:DATA_WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inj_en_q <= 1'b0;
         armed    <= 1'b0;
         inj_done <= 1'b0;
         enc_cnt  <= '0;
         inj_cnt  <= '0;
      end else begin
         inj_en_q <= inj_en;
         inj_done <= inj_acc;
         if (!inj_en)
            armed <= 1'b0;
         else if (inj_acc && inj_oneshot)
            armed <= 1'b0;
         else if (inj_rise)
            armed <= 1'b1;
         if (accept && (enc_cnt != {CNT_WIDTH{1'b1}}))
            enc_cnt <= enc_cnt + 1'b1;
         if (inj_acc && (inj_cnt != {CNT_WIDTH{1'b1}}))
            inj_cnt <= inj_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_ecc_24_wr_enc.sv
// Directed self-checking bench for ecc_24_wr_enc with hand-computed codewords.
`timescale 1ns/1ps
module tb_ecc_24_wr_enc;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] out_data;
   logic [5:0]  out_parity;
   logic        inj_en;
   logic [1:0]  inj_mode;
   logic [4:0]  inj_pos;
   logic        inj_oneshot;
   logic        inj_done;
   logic [15:0] enc_cnt;
   logic [15:0] inj_cnt;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   ecc_24_wr_enc #(.CNT_WIDTH(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_parity  (out_parity),
      .inj_en      (inj_en),
      .inj_mode    (inj_mode),
      .inj_pos     (inj_pos),
      .inj_oneshot (inj_oneshot),
      .inj_done    (inj_done),
      .enc_cnt     (enc_cnt),
      .inj_cnt     (inj_cnt)
   );

   // Present one word from posedge+1, let it be accepted, return at posedge+1.
   task automatic send_word(input logic [23:0] d);
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL send_in_ready got %b want 1", in_ready);
      else pass_cnt++;
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      total_cnt++;
      if ({out_valid, in_ready, inj_done} !== 3'b010 || out_data !== 24'h0 || out_parity !== 6'h0
          || enc_cnt !== 16'h0 || inj_cnt !== 16'h0)
         $display("FAIL reset_state got v=%b r=%b d=%h p=%h e=%0d i=%0d", out_valid, in_ready,
                  out_data, out_parity, enc_cnt, inj_cnt);
      else pass_cnt++;
   endtask

   task automatic test_encode();
      logic [23:0] din  [3] = '{24'h000000, 24'h000001, 24'hFFFFFF};
      logic [5:0]  pexp [3] = '{6'h00, 6'h23, 6'h1E};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = din[i];
         @(posedge clk); #1;
         total_cnt++;
         if (out_valid !== 1'b1 || out_data !== din[i] || out_parity !== pexp[i] || in_ready !== 1'b1)
            $display("FAIL encode_%0d got v=%b d=%h p=%h r=%b want d=%h p=%h", i, out_valid,
                     out_data, out_parity, in_ready, din[i], pexp[i]);
         else pass_cnt++;
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      total_cnt++;
      if (out_valid !== 1'b0 || enc_cnt !== 16'd3)
         $display("FAIL encode_drain got v=%b enc_cnt=%0d want v=0 enc_cnt=3", out_valid, enc_cnt);
      else pass_cnt++;
   endtask

   task automatic test_inj_single();
      inj_en = 1'b1; inj_mode = 2'b01; inj_pos = 5'd0; inj_oneshot = 1'b1;
      @(posedge clk); #1;
      send_word(24'h000000);
      total_cnt++;
      if (out_data !== 24'h000001 || out_parity !== 6'h00 || inj_done !== 1'b1)
         $display("FAIL inj_sbit got d=%h p=%h done=%b want d=000001 p=00 done=1", out_data, out_parity, inj_done);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (inj_done !== 1'b0) $display("FAIL inj_done_pulse got %b want 0", inj_done);
      else pass_cnt++;
      send_word(24'h000000);
      total_cnt++;
      if (out_data !== 24'h000000 || out_parity !== 6'h00 || inj_done !== 1'b0 || inj_cnt !== 16'd1)
         $display("FAIL inj_disarm got d=%h p=%h done=%b inj_cnt=%0d want d=000000 done=0 inj_cnt=1",
                  out_data, out_parity, inj_done, inj_cnt);
      else pass_cnt++;
      inj_en = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_inj_double();
      inj_en = 1'b1; inj_mode = 2'b10; inj_pos = 5'd23; inj_oneshot = 1'b1;
      @(posedge clk); #1;
      send_word(24'h000000);
      total_cnt++;
      if (out_data !== 24'h800001 || out_parity !== 6'h00 || inj_done !== 1'b1)
         $display("FAIL inj_dbit got d=%h p=%h done=%b want d=800001 p=00 done=1", out_data, out_parity, inj_done);
      else pass_cnt++;
      inj_en = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_inj_parity();
      inj_en = 1'b1; inj_mode = 2'b11; inj_pos = 5'd9; inj_oneshot = 1'b1;
      @(posedge clk); #1;
      send_word(24'h000001);
      total_cnt++;
      if (out_data !== 24'h000001 || out_parity !== 6'h22 || inj_cnt !== 16'd3)
         $display("FAIL inj_pbit got d=%h p=%h inj_cnt=%0d want d=000001 p=22 inj_cnt=3", out_data, out_parity, inj_cnt);
      else pass_cnt++;
      inj_en = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_inj_continuous();
      inj_en = 1'b1; inj_mode = 2'b01; inj_pos = 5'd30; inj_oneshot = 1'b0;
      @(posedge clk); #1;
      send_word(24'h000000);
      total_cnt++;
      if (out_data !== 24'h000001 || out_parity !== 6'h00)
         $display("FAIL inj_cont0 got d=%h p=%h want d=000001 p=00", out_data, out_parity);
      else pass_cnt++;
      send_word(24'h000002);
      total_cnt++;
      if (out_data !== 24'h000003 || out_parity !== 6'h25 || inj_cnt !== 16'd5)
         $display("FAIL inj_cont1 got d=%h p=%h inj_cnt=%0d want d=000003 p=25 inj_cnt=5", out_data, out_parity, inj_cnt);
      else pass_cnt++;
      inj_en = 1'b0;
      send_word(24'h000000);
      total_cnt++;
      if (out_data !== 24'h000000 || inj_done !== 1'b0 || enc_cnt !== 16'd10)
         $display("FAIL inj_cont_off got d=%h done=%b enc_cnt=%0d want d=000000 done=0 enc_cnt=10",
                  out_data, inj_done, enc_cnt);
      else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [23:0] words [8];
      logic [5:0]  pars  [8] = '{6'h23, 6'h25, 6'h26, 6'h07, 6'h29, 6'h2A, 6'h0B, 6'h2C};
      logic        pat   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int          idx = 0, oidx = 0, occ = 0, cyc = 0;
      logic        prev_stall = 1'b0, will_acc, will_out;
      logic [29:0] prev_cw = '0;
      for (int i = 0; i < 8; i++) words[i] = 24'h1 << i;
      while (oidx < 8 && cyc < 100) begin
         out_ready = pat[cyc % 4];
         in_valid  = (idx < 8);
         in_data   = (idx < 8) ? words[idx] : 24'h0;
         total_cnt++;
         if (in_ready !== (occ < 2) || out_valid !== (occ > 0))
            $display("FAIL bp_flow cyc=%0d got r=%b v=%b occ=%0d", cyc, in_ready, out_valid, occ);
         else pass_cnt++;
         if (prev_stall) begin
            total_cnt++;
            if ({out_parity, out_data} !== prev_cw)
               $display("FAIL bp_stable cyc=%0d got %h want %h", cyc, {out_parity, out_data}, prev_cw);
            else pass_cnt++;
         end
         will_acc = in_valid & in_ready;
         will_out = out_valid & out_ready;
         if (will_out) begin
            total_cnt++;
            if (out_data !== words[oidx] || out_parity !== pars[oidx])
               $display("FAIL bp_order_%0d got d=%h p=%h want d=%h p=%h", oidx, out_data, out_parity,
                        words[oidx], pars[oidx]);
            else pass_cnt++;
            oidx++;
         end
         prev_stall = out_valid & ~out_ready;
         prev_cw    = {out_parity, out_data};
         @(posedge clk); #1;
         if (will_acc) begin idx++; occ++; end
         if (will_out) occ--;
         cyc++;
      end
      in_valid = 1'b0;
      total_cnt++;
      if (oidx != 8) $display("FAIL bp_timeout got %0d words want 8", oidx);
      else pass_cnt++;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_stall();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 24'h000010;
      @(posedge clk); #1;
      in_data   = 24'h000020;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      total_cnt++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1)
         $display("FAIL stall_full got r=%b v=%b want r=0 v=1", in_ready, out_valid);
      else pass_cnt++;
      #2 rst = 1'b1;
      #1;
      total_cnt++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || enc_cnt !== 16'd0 || inj_cnt !== 16'd0
          || out_data !== 24'h0 || out_parity !== 6'h0)
         $display("FAIL async_reset got v=%b r=%b e=%0d i=%0d d=%h p=%h", out_valid, in_ready,
                  enc_cnt, inj_cnt, out_data, out_parity);
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      send_word(24'h000008);
      total_cnt++;
      if (out_valid !== 1'b1 || out_data !== 24'h000008 || out_parity !== 6'h07 || enc_cnt !== 16'd1)
         $display("FAIL post_reset got v=%b d=%h p=%h e=%0d want v=1 d=000008 p=07 e=1", out_valid,
                  out_data, out_parity, enc_cnt);
      else pass_cnt++;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      inj_en = 1'b0; inj_mode = 2'b00; inj_pos = '0; inj_oneshot = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      test_reset();
      test_encode();
      test_inj_single();
      test_inj_double();
      test_inj_parity();
      test_inj_continuous();
      test_back_to_back();
      test_reset_mid_stall();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/ecc_24_wr_enc.md
Name: ecc_24_wr_enc

Overview:
Write-side SECDED encoder for the 24-bit ECC-protected FIFO path. It is the producer end of the 24-data + 6-parity codeword that the read-side checker corrects and flags. It accepts data through a valid/ready handshake and computes parity. It registers the 30-bit codeword into a skid-buffered output stage that feeds the FIFO RAM write port. It also provides a deterministic error-injection facility so the read-side checker can be exercised in silicon and in simulation.

Parameters:
DATA_WIDTH, 24, data bits per codeword. Fixed by the H-matrix; other values are unsupported.
PARITY_WIDTH, 6, parity bits per codeword.
CNT_WIDTH, 16, width of the saturating encoded-word and injected-word counters.

Ports:
clk  in  1  single clock for all state
rst  in  1  asynchronous, active-high reset
in_valid  in  1  upstream word valid
in_ready  out  1  block can accept a word
in_data  in  24  upstream data
out_valid  out  1  codeword valid to FIFO write port
out_ready  in  1  FIFO write port accepts codeword
out_data  out  24  codeword data bits, possibly corrupted by injection
out_parity  out  6  codeword parity bits, possibly corrupted by injection
inj_en  in  1  injection enable, level
inj_mode  in  2  00 none, 01 single data bit, 10 double data bit, 11 single parity bit
inj_pos  in  5  bit index for injection
inj_oneshot  in  1  1: inject into one word then disarm; 0: inject into every word while inj_en=1
inj_done  out  1  one-cycle pulse when an injected word is accepted
enc_cnt  out  CNT_WIDTH  saturating count of accepted words
inj_cnt  out  CNT_WIDTH  saturating count of injected words

Behaviour:
- Parity is computed on the clean in_data. Each p[i] is the XOR of the data bits in parity-set i (see Decomposition).
- Injection is applied after encoding, on the accepted word. Parity is never recomputed after corruption.
- A word is accepted when in_valid & in_ready. out_data/out_parity are registered, giving 1-cycle latency from acceptance to out_valid.
- Output stage is a main register plus a 1-entry skid register. The block sustains 1 word/cycle with out_ready=1.
- in_ready = !skid_valid, driven from a flop.
- When out_valid & !out_ready and a word is accepted, the word goes to skid. When the main register drains, skid moves to main.
- out_* are held stable while out_valid & !out_ready.
- Arm logic: armed is set on the rising edge of inj_en with inj_mode!=00.
  - Oneshot mode: armed clears after one injected acceptance.
  - Continuous mode: injection applies while inj_en=1 & inj_mode!=00.
  - inj_en=0 clears armed immediately.
  - inj_mode, inj_pos and inj_oneshot are sampled at acceptance.
- Mode 01 flips data[p]. Mode 10 flips data[p] and data[(p+1) mod 24]. In both, p = inj_pos if inj_pos<24, else 0.
- Mode 11 flips parity[q], where q = inj_pos if inj_pos<6, else 0.
- inj_done pulses 1 cycle after an injected acceptance, aligned with that word entering the output stage.
- enc_cnt increments per accepted word. inj_cnt increments per injected word. Both saturate at all-ones and never wrap.
- Reset (asynchronous, any time including mid-transfer) clears:
  - out_valid=0, skid_valid=0, in_ready=1;
  - out_data=0, out_parity=0;
  - inj_done=0, armed=0, enc_cnt=0, inj_cnt=0.
  - Words in flight are discarded.
- Word ordering is strictly preserved. No word is dropped or duplicated under any out_ready pattern.

Decomposition:
- Package ecc24_pkg holds:
  - DATA_WIDTH and PARITY_WIDTH constants;
  - injection mode encodings INJ_NONE, INJ_SBIT, INJ_DBIT, INJ_PBIT;
  - parity-set constants:
    P0 = d0,1,3,4,6,8,10,11,13,15,17,19,21,23
    P1 = d0,2,3,5,6,9,10,12,13,16,17,20,21
    P2 = d1,2,3,7,8,9,10,14,15,16,17,22,23
    P3 = d4..10,18..23
    P4 = d11..23
    P5 = d0,1,2,4,5,7,10,11,12,14,17,18,21,23
  - the ecc24_encode function.
- The read-side checker uses the same package so the encoder and checker cannot diverge.
- One sub-module, ecc_skid_buf: generic 2-entry valid/ready register slice, parameterised on width (30).

Test Plan:
- No injection, out_ready=1: send in_data 0x000000, 0x000001, 0xFFFFFF. Expect out_parity 0x00, 0x23, 0x1E respectively, 1 cycle after acceptance each; enc_cnt=3.
- inj_en=1, mode 01, pos 0, oneshot, in_data 0x000000. Expect out_data 0x000001, out_parity 0x00, one inj_done pulse. The next word is clean; inj_cnt=1. The checker flags sbit_err and corrects to 0.
- Mode 10, pos 23, in_data 0x000000. Expect out_data 0x800001, out_parity 0x00. The checker flags dbit_err.
- Mode 11, pos 9 (out of range), in_data 0x000001. Expect out_parity 0x22 (bit 0 flipped), out_data 0x000001.
- Backpressure: stream 8 words with out_ready toggling 1,0,0,1. Expect in_ready low only when skid is full, out_* stable while stalled, all 8 words out in order, no gaps at full rate.
- Assert rst mid-stall with 2 words buffered. Expect out_valid=0, in_ready=1, counters 0 asynchronously. After release, the first new word encodes correctly with 1-cycle latency.
